fetch_stage: RTL and testbench

Instruction-fetch stage of the single-issue pipelined CPU. Owns the program counter, drives the word address into the combinational instruction memory, and captures the returned instruction into the IF/ID pipeline register. Downstream decode consumes it through a valid/ready handshake. Execute redirects fetch on taken branches and jumps.

---
 rtl/cpu_pkg.sv | 17 +
 rtl/fetch_pc_gen.sv | 41 ++++
 rtl/fetch_stage.sv | 82 ++++++++
 tb/tb_fetch_stage.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: datapath width, NOP encoding, reset vector and
// the IF/ID pipeline register layout.
package cpu_pkg;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] NOP_INSTR        = 32'h0000_0013;
  localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef struct packed {
    logic            valid;
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc_plus4;
    logic            fault;
  } ifid_t;

endpackage

// File: rtl/fetch_pc_gen.sv
// Program counter register and next-PC selection for the fetch stage.
// Selection order: redirect, then sequential +4 on advance, else hold.
module fetch_pc_gen
  import cpu_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  input  logic            advance,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] pc_plus4
);

  logic [XLEN-1:0] pc_reg;
  logic [XLEN-1:0] pc_next;

  // 32-bit add wraps naturally at the top of the address space.
  assign pc_plus4 = pc_reg + 32'd4;
  assign pc       = pc_reg;

  always_comb begin
    pc_next = pc_reg;
    if (redirect_valid) begin
      pc_next = redirect_pc;
    end else if (advance) begin
      pc_next = pc_plus4;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_reg <= RESET_PC;
    end else begin
      pc_reg <= pc_next;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: drives the PC to the instruction memory and captures the
// result into the IF/ID register. Optional range/alignment check: FETCH_FAULT_EN.
module fetch_stage
  import cpu_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC   = DEFAULT_RESET_PC,
  parameter int              IMEM_DEPTH = 1024
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic [XLEN-1:0] imem_addr,
  input  logic [XLEN-1:0] imem_instr,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_instr,
  output logic [XLEN-1:0] out_pc,
  output logic [XLEN-1:0] out_pc_plus4,
  output logic            out_fault
);

  ifid_t           ifid_reg;
  ifid_t           ifid_next;
  logic            advance;
  logic            fetch_fault;
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] pc_plus4;

  assign advance = !ifid_reg.valid || out_ready;

  fetch_pc_gen #(
    .RESET_PC (RESET_PC)
  ) u_pc_gen (
    .clk            (clk),
    .rst_n          (rst_n),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .advance        (advance),
    .pc             (pc),
    .pc_plus4       (pc_plus4)
  );

  assign imem_addr = pc;

`ifdef FETCH_FAULT_EN
  assign fetch_fault = (pc[1:0] != 2'b00) ||
                       ({2'b00, pc[XLEN-1:2]} >= 32'(IMEM_DEPTH));
`else
  localparam int unused_imem_depth = IMEM_DEPTH;
  assign fetch_fault = 1'b0;
`endif

  // A faulting slot carries a NOP so an undefined memory word never propagates.
  always_comb begin
    ifid_next = ifid_reg;
    if (redirect_valid) begin
      ifid_next.valid = 1'b0;
    end else if (advance) begin
      ifid_next.valid    = 1'b1;
      ifid_next.instr    = fetch_fault ? NOP_INSTR : imem_instr;
      ifid_next.pc       = pc;
      ifid_next.pc_plus4 = pc_plus4;
      ifid_next.fault    = fetch_fault;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ifid_reg <= '0;
    end else begin
      ifid_reg <= ifid_next;
    end
  end

  assign out_valid    = ifid_reg.valid;
  assign out_instr    = ifid_reg.instr;
  assign out_pc       = ifid_reg.pc;
  assign out_pc_plus4 = ifid_reg.pc_plus4;
  assign out_fault    = ifid_reg.fault;

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios with literal
// expectations, then randomized traffic against a behavioural model.
module tb_fetch_stage;

  localparam logic [31:0] RST_PC = 32'h0000_0000;
  localparam int          DEPTH  = 1024;
  localparam logic [31:0] NOP    = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] imem_addr;
  logic [31:0] imem_instr;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic [31:0] out_pc_plus4;
  logic        out_fault;

  logic [31:0] mem [0:DEPTH-1];

  int errors = 0;
  int checks = 0;
  int xfers  = 0;

  // Behavioural model state
  logic [31:0] m_pc;
  logic        m_valid;
  logic [31:0] m_instr;
  logic [31:0] m_opc;
  logic        m_fault;

  always #5 clk = ~clk;

  assign imem_instr = mem[imem_addr[11:2]];

  fetch_stage #(
    .RESET_PC   (RST_PC),
    .IMEM_DEPTH (DEPTH)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_addr      (imem_addr),
    .imem_instr     (imem_instr),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_instr      (out_instr),
    .out_pc         (out_pc),
    .out_pc_plus4   (out_pc_plus4),
    .out_fault      (out_fault)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic fault_of(input logic [31:0] a);
`ifdef FETCH_FAULT_EN
    return (a % 4 != 0) || (a >= 32'(DEPTH * 4));
`else
    return 1'b0;
`endif
  endfunction

  // Apply one clock edge's worth of the fetch rules to the model.
  task automatic model_step();
    if (!rst_n) begin
      m_pc = RST_PC; m_valid = 0; m_instr = 0; m_opc = 0; m_fault = 0;
    end else if (redirect_valid) begin
      m_pc = redirect_pc; m_valid = 0;
    end else if (!m_valid || out_ready) begin
      if (m_valid) begin
        xfers++;
        $display("xfer %0d: pc=%h instr=%h fault=%0b", xfers, m_opc, m_instr, m_fault);
      end
      m_fault = fault_of(m_pc);
      m_instr = m_fault ? NOP : mem[m_pc[11:2]];
      m_opc   = m_pc;
      m_valid = 1;
      m_pc    = m_pc + 4;
    end
  endtask

  task automatic compare_all();
    chk("imem_addr", imem_addr, m_pc);
    chk("out_valid", {31'b0, out_valid}, {31'b0, m_valid});
    if (m_valid) begin
      chk("out_pc",       out_pc,       m_opc);
      chk("out_pc_plus4", out_pc_plus4, m_opc + 32'd4);
      chk("out_instr",    out_instr,    m_instr);
      chk("out_fault",    {31'b0, out_fault}, {31'b0, m_fault});
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
    compare_all();
  endtask

  logic exp_f;
  logic [31:0] exp_i;

  initial begin
    for (int i = 0; i < DEPTH; i++) mem[i] = $urandom;
    m_pc = RST_PC; m_valid = 0; m_instr = 0; m_opc = 0; m_fault = 0;
    rst_n = 0; out_ready = 1; redirect_valid = 0; redirect_pc = 0;
    #2;

    // Reset state
    cycle(); cycle();
    chk("rst_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_instr", out_instr, 32'd0);
    chk("rst_pc", out_pc, 32'd0);
    chk("rst_pc4", out_pc_plus4, 32'd0);
    chk("rst_fault", {31'b0, out_fault}, 32'd0);
    chk("rst_addr", imem_addr, RST_PC);

    // Streaming from reset
    rst_n = 1;
    cycle(); chk("seq0_pc", out_pc, 32'd0); chk("seq0_instr", out_instr, mem[0]);
    cycle(); chk("seq1_pc", out_pc, 32'd4); chk("seq1_instr", out_instr, mem[1]);
    cycle(); chk("seq2_pc", out_pc, 32'd8); chk("seq2_instr", out_instr, mem[2]);

    // Stall at pc 8 for three cycles
    out_ready = 0;
    for (int k = 0; k < 3; k++) begin
      cycle();
      chk("stall_pc", out_pc, 32'd8);
      chk("stall_addr", imem_addr, 32'd12);
      chk("stall_valid", {31'b0, out_valid}, 32'd1);
    end
    out_ready = 1;
    cycle(); chk("rel_pc", out_pc, 32'd12); chk("rel_instr", out_instr, mem[3]);

    // Redirect while stalled
    out_ready = 0; redirect_valid = 1; redirect_pc = 32'h40;
    cycle(); chk("redir_bubble", {31'b0, out_valid}, 32'd0);
    redirect_valid = 0; out_ready = 1;
    cycle(); chk("redir_pc", out_pc, 32'h40); chk("redir_pc4", out_pc_plus4, 32'h44);

    // Reset beats a pending redirect
    rst_n = 0; redirect_valid = 1; redirect_pc = 32'h80;
    cycle();
    chk("rr_valid", {31'b0, out_valid}, 32'd0);
    chk("rr_pc", out_pc, 32'd0);
    chk("rr_instr", out_instr, 32'd0);
    chk("rr_addr", imem_addr, RST_PC);
    rst_n = 1; redirect_valid = 0;
    cycle(); chk("rr_first", out_pc, RST_PC);

`ifdef FETCH_FAULT_EN
    exp_f = 1'b1; exp_i = NOP;
`else
    exp_f = 1'b0; exp_i = mem[0];
`endif
    // Misaligned, then out-of-range targets
    redirect_valid = 1; redirect_pc = 32'h1002;
    cycle(); redirect_valid = 0;
    cycle();
    chk("mis_pc", out_pc, 32'h1002);
    chk("mis_fault", {31'b0, out_fault}, {31'b0, exp_f});
    chk("mis_instr", out_instr, exp_i);
    redirect_valid = 1; redirect_pc = 32'h1000;
    cycle(); redirect_valid = 0;
    cycle();
    chk("oor_pc", out_pc, 32'h1000);
    chk("oor_fault", {31'b0, out_fault}, {31'b0, exp_f});
    chk("oor_instr", out_instr, exp_i);

    // Wrap at the top of the address space
    redirect_valid = 1; redirect_pc = 32'hFFFF_FFFC;
    cycle(); redirect_valid = 0;
    cycle(); chk("wrap_pc", out_pc, 32'hFFFF_FFFC); chk("wrap_pc4", out_pc_plus4, 32'd0);
    cycle(); chk("wrap_next", out_pc, 32'd0);

    // Randomized traffic
    for (int n = 0; n < 400; n++) begin
      out_ready      = ($urandom_range(0, 3) != 0);
      redirect_valid = ($urandom_range(0, 9) == 0);
      if ($urandom_range(0, 4) == 0) redirect_pc = $urandom;
      else redirect_pc = {20'b0, 10'($urandom_range(0, DEPTH - 1)), 2'b00};
      rst_n = ($urandom_range(0, 59) != 0);
      cycle();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
